fifo_multi_enq: RTL and testbench
=================================

// Module: fifo_multi_enq
// PURPOSE
//  Parametrised successor of the dual-port enqueue FIFO. Accepts up to NUM_IN
//  words per cycle on independent enqueue lanes, packed in lane order, and
//  delivers one word per cycle on a first-word-fall-through dequeue port.
//  Sits between parallel producers (e.g. multi-lane parsers) and a single
//  consumer. Depth may be any integer >= NUM_IN (non-power-of-two allowed).
// PARAMETERS
//  DWIDTH      64  data word width in bits
//  QUEUE_SIZE  21  storage entries; any value >= NUM_IN
//  NUM_IN      2   enqueue lanes, 1..8
//  AFULL_LVL   16  almost_full asserts when count >= AFULL_LVL
// PORTS
//  clk           in   1                 clock; all logic on posedge
//  rst           in   1                 synchronous, active-low reset
//  in_enque_en   in   NUM_IN            per-lane enqueue request; lane i = bit i
//  in_data       in   NUM_IN*DWIDTH     lane i data in bits [i*DWIDTH +: DWIDTH]
//  in_valid      out  1                 1 = at least NUM_IN free entries this cycle
//  out_deque_en  in   1                 pop head word when out_valid=1
//  out_valid     out  1                 1 = FIFO non-empty; out_data is valid
//  out_data      out  DWIDTH            head word (FWFT, combinational from storage)
//  count         out  $clog2(QUEUE_SIZE+1)  occupied entries
//  almost_full   out  1                 count >= AFULL_LVL
//  overflow_err  out  1                 sticky; set on any enqueue while in_valid=0
// BEHAVIOUR
//  - Reset (rst==0 at posedge): wr_ptr=rd_ptr=0, count=0, overflow_err=0;
//    hence out_valid=0, in_valid=1, almost_full=(AFULL_LVL==0). Storage is not cleared.
//  - in_valid = (QUEUE_SIZE - count) >= NUM_IN; computed from registered count
//    only (no credit for same-cycle dequeue).
//  - Enqueue: when in_valid=1, the k = popcount(in_enque_en) enabled lanes are
//    written at wr_ptr, wr_ptr+1, ... in ascending lane index (disabled lanes
//    are skipped and leave no gap). wr_ptr advances by k modulo QUEUE_SIZE.
//    Write visible at out_data the cycle after the edge (1-cycle latency).
//  - Enqueue while in_valid=0: all lanes dropped, no state change except
//    overflow_err<=1 (if any enable is set).
//  - Dequeue: out_deque_en & out_valid -> rd_ptr advances by 1 modulo
//    QUEUE_SIZE. out_deque_en while empty is ignored, no error.
//  - Simultaneous enqueue k and dequeue d: count <= count + k - d. When empty,
//    a same-cycle enqueue is not bypassed to out_data.
//  - Pointer wrap: explicit compare to QUEUE_SIZE-1, no reliance on 2^n rollover;
//    multi-lane writes may straddle the wrap point (index = (wr_ptr+j) mod QUEUE_SIZE).
//  - Reset mid-operation: contents discarded, in-flight enqueue/dequeue of that
//    cycle has no effect.
//  - Widths: count and pointer arithmetic sized for QUEUE_SIZE+NUM_IN without
//    truncation before modulo reduction.
// STRUCTURE
//  - Package fifo_pkg: function wrap_add(ptr, inc, size), localparams
//    PTR_W=$clog2(QUEUE_SIZE), CNT_W=$clog2(QUEUE_SIZE+1).
//  - Sub-module lane_compactor: combinational prefix-popcount of in_enque_en;
//    outputs per-lane write offset and total k. Top holds storage, pointers,
//    count and flags.
// TESTING
//  1. Reset: rst=0 two cycles -> out_valid=0, in_valid=1, count=0, overflow_err=0.
//  2. Dual fill, NUM_IN=2, QUEUE_SIZE=21: both lanes data=114514 every cycle ->
//     count 2,4,..,18; after count=20 in_valid=0; further writes set overflow_err, count stays 20.
//  3. Lane packing: in_enque_en=2'b10 data B=7, then 2'b11 A=8,B=9 -> pop order 7,8,9.
//  4. Wrap: fill 20, pop 19, write pairs until ptr passes index 20 -> pop sequence
//     matches write order across wrap; count never exceeds 21.
//  5. Concurrent: count=5, enq 2 + deque 1 each cycle for 3 cycles -> count=8;
//     deque on empty -> count stays 0, out_valid=0.
//  6. Reset mid-stream at count=10 -> next cycle count=0, out_valid=0, overflow_err=0.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fifo_pkg                                                         |
// | Brief   : Shared pointer arithmetic and sizing helpers for fifo_multi_enq. |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package fifo_pkg;

    localparam int unsigned DEF_QUEUE_SIZE = 21;
    localparam int unsigned PTR_W          = (DEF_QUEUE_SIZE > 1) ? $clog2(DEF_QUEUE_SIZE) : 1;
    localparam int unsigned CNT_W          = $clog2(DEF_QUEUE_SIZE + 1);

    // Modulo add without relying on power-of-two rollover; inc never exceeds size.
    function automatic int unsigned wrap_add(
        input int unsigned ptr,
        input int unsigned inc,
        input int unsigned size
    );
        int unsigned sum;
        sum = ptr + inc;
        if (sum >= size) begin
            sum = sum - size;
        end
        return sum;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_compactor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lane_compactor                                                   |
// | Brief   : Prefix popcount of lane enables -> packed write offsets + total. |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module lane_compactor #(
    parameter int unsigned NUM_IN = 2,
    parameter int unsigned OFF_W  = $clog2(NUM_IN + 1)
) (
    input  logic [NUM_IN-1:0]       i_enable,
    output logic [NUM_IN*OFF_W-1:0] o_offset,
    output logic [OFF_W-1:0]        o_total
);

    always_comb begin
        logic [OFF_W-1:0] w_run;
        w_run    = '0;
        o_offset = '0;
        // Each lane's offset is the number of enabled lanes below it.
        for (int i = 0; i < int'(NUM_IN); i++) begin
            o_offset[i*OFF_W +: OFF_W] = w_run;
            w_run = w_run + OFF_W'(i_enable[i]);
        end
        o_total = w_run;
    end

endmodule
`default_nettype wire

// File: rtl/fifo_multi_enq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fifo_multi_enq                                                   |
// | Brief   : Multi-lane enqueue, single FWFT dequeue FIFO of arbitrary depth. |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module fifo_multi_enq
    import fifo_pkg::*;
#(
    parameter int unsigned DWIDTH     = 64,
    parameter int unsigned QUEUE_SIZE = 21,
    parameter int unsigned NUM_IN     = 2,
    parameter int unsigned AFULL_LVL  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_IN-1:0]               in_enque_en,
    input  logic [NUM_IN*DWIDTH-1:0]        in_data,
    output logic                            in_valid,
    input  logic                            out_deque_en,
    output logic                            out_valid,
    output logic [DWIDTH-1:0]               out_data,
    output logic [$clog2(QUEUE_SIZE+1)-1:0] count,
    output logic                            almost_full,
    output logic                            overflow_err
);

    localparam int unsigned C_PTR_W = ptr_width(QUEUE_SIZE);
    localparam int unsigned C_CNT_W = $clog2(QUEUE_SIZE + 1);
    localparam int unsigned C_OFF_W = $clog2(NUM_IN + 1);
    localparam int unsigned C_SUM_W = $clog2(QUEUE_SIZE + NUM_IN + 1);

    logic [DWIDTH-1:0]               r_mem [QUEUE_SIZE];
    logic [C_PTR_W-1:0]              r_wr_ptr;
    logic [C_PTR_W-1:0]              r_rd_ptr;
    logic [C_CNT_W-1:0]              r_count;
    logic                            r_overflow;

    logic [NUM_IN*C_OFF_W-1:0]       w_offset;
    logic [C_OFF_W-1:0]              w_total;
    logic [NUM_IN-1:0][C_PTR_W-1:0]  w_lane_idx;
    logic                            w_accept;
    logic                            w_pop;
    logic [C_SUM_W-1:0]              w_count_next;

    lane_compactor #(
        .NUM_IN (NUM_IN),
        .OFF_W  (C_OFF_W)
    ) u_lane_compactor (
        .i_enable (in_enque_en),
        .o_offset (w_offset),
        .o_total  (w_total)
    );

    // Space is judged on the registered count only; a same-cycle pop earns no credit.
    assign w_accept = (32'(r_count) + NUM_IN) <= QUEUE_SIZE;
    assign w_pop    = out_deque_en && (r_count != '0);

    generate
        for (genvar gi = 0; gi < int'(NUM_IN); gi++) begin : g_lane_idx
            assign w_lane_idx[gi] = C_PTR_W'(wrap_add(32'(r_wr_ptr),
                                                      32'(w_offset[gi*C_OFF_W +: C_OFF_W]),
                                                      QUEUE_SIZE));
        end
    endgenerate

    assign w_count_next = C_SUM_W'(r_count)
                        + (w_accept ? C_SUM_W'(w_total) : C_SUM_W'(0))
                        - C_SUM_W'(w_pop);

    always_ff @(posedge clk) begin
        if (rst && w_accept) begin
            for (int i = 0; i < int'(NUM_IN); i++) begin
                if (in_enque_en[i]) begin
                    r_mem[w_lane_idx[i]] <= in_data[i*DWIDTH +: DWIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= C_PTR_W'(wrap_add(32'(r_wr_ptr), 32'(w_total), QUEUE_SIZE));
            end else if (|in_enque_en) begin
                r_overflow <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= C_PTR_W'(wrap_add(32'(r_rd_ptr), 32'd1, QUEUE_SIZE));
            end
            r_count <= C_CNT_W'(w_count_next);
        end
    end

    assign in_valid     = w_accept;
    assign out_valid    = (r_count != '0);
    assign out_data     = r_mem[r_rd_ptr];
    assign count        = r_count;
    assign almost_full  = 32'(r_count) >= AFULL_LVL;
    assign overflow_err = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_multi_enq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_fifo_multi_enq                                                |
// | Brief   : Scenario tasks plus random traffic against a queue-based model.  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_fifo_multi_enq;

    localparam int DW = 64;
    localparam int QS = 21;
    localparam int NI = 2;
    localparam int AF = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NI-1:0]     en;
    logic [NI*DW-1:0]  data;
    logic              in_valid;
    logic              deq;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [4:0]        count;
    logic              almost_full;
    logic              overflow_err;

    logic [DW-1:0]     mq[$];
    bit                m_ovf;
    int                errors = 0;
    int                checks = 0;

    fifo_multi_enq #(
        .DWIDTH     (DW),
        .QUEUE_SIZE (QS),
        .NUM_IN     (NI),
        .AFULL_LVL  (AF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_enque_en  (en),
        .in_data      (data),
        .in_valid     (in_valid),
        .out_deque_en (deq),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .count        (count),
        .almost_full  (almost_full),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    // One clock: drive at negedge, apply the FIFO rules to the model at posedge.
    task automatic cycle(input logic [1:0] e, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input logic dq);
        int sz;
        bit iv;
        en   = e;
        data = {d1, d0};
        deq  = dq;
        @(posedge clk);
        if (!rst) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            sz = mq.size();
            iv = (QS - sz) >= NI;
            if (dq && sz > 0) void'(mq.pop_front());
            if (e != 2'b00) begin
                if (iv) begin
                    if (e[0]) mq.push_back(d0);
                    if (e[1]) mq.push_back(d1);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cycle(2'b00, '0, '0, 1'b0);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cycle(2'b11, 64'd1, 64'd2, 1'b1);
        cycle(2'b00, '0, '0, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_valid !== 1'b1) begin errors++; $display("FAIL reset_in_valid got=%b exp=1", in_valid); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow_err); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full got=%b exp=0", almost_full); end
        rst = 1'b1;
    endtask

    task automatic test_dual_fill();
        int exp;
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            cycle(2'b11, 64'd114514, 64'd114514, 1'b0);
            exp = (2 * i > 20) ? 20 : 2 * i;
            checks++; if (count !== 5'(exp)) begin errors++; $display("FAIL fill_count cyc=%0d got=%0d exp=%0d", i, count, exp); end
            checks++; if (in_valid !== (exp <= QS - NI)) begin errors++; $display("FAIL fill_in_valid cyc=%0d got=%b exp=%b", i, in_valid, exp <= QS - NI); end
            checks++; if (almost_full !== (exp >= AF)) begin errors++; $display("FAIL fill_almost_full cyc=%0d got=%b exp=%b", i, almost_full, exp >= AF); end
            checks++; if (overflow_err !== (i > 10)) begin errors++; $display("FAIL fill_overflow cyc=%0d got=%b exp=%b", i, overflow_err, i > 10); end
        end
        checks++; if (out_data !== 64'd114514) begin errors++; $display("FAIL fill_head got=%0d exp=114514", out_data); end
    endtask

    task automatic test_lane_packing();
        logic [DW-1:0] exp_seq [3];
        exp_seq = '{64'd7, 64'd8, 64'd9};
        do_reset();
        cycle(2'b10, 64'hdead, 64'd7, 1'b0);
        cycle(2'b11, 64'd8, 64'd9, 1'b0);
        checks++; if (count !== 5'd3) begin errors++; $display("FAIL pack_count got=%0d exp=3", count); end
        for (int j = 0; j < 3; j++) begin
            checks++; if (!out_valid || out_data !== exp_seq[j]) begin
                errors++; $display("FAIL pack_pop j=%0d got=%0d valid=%b exp=%0d", j, out_data, out_valid, exp_seq[j]);
            end
            cycle(2'b00, '0, '0, 1'b1);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pack_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] exp;
        do_reset();
        for (int i = 0; i < 10; i++) cycle(2'b11, 64'(100 + 2 * i), 64'(101 + 2 * i), 1'b0);
        for (int i = 0; i < 19; i++) cycle(2'b00, '0, '0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            cycle(2'b11, 64'(200 + 2 * i), 64'(201 + 2 * i), 1'b0);
            checks++; if (count > 5'd21 || count !== 5'(3 + 2 * i)) begin
                errors++; $display("FAIL wrap_count i=%0d got=%0d exp=%0d", i, count, 3 + 2 * i);
            end
        end
        for (int j = 0; j < 19; j++) begin
            exp = (j == 0) ? 64'd119 : 64'(199 + j);
            checks++; if (!out_valid || out_data !== exp) begin
                errors++; $display("FAIL wrap_pop j=%0d got=%0d valid=%b exp=%0d", j, out_data, out_valid, exp);
            end
            cycle(2'b00, '0, '0, 1'b1);
        end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL wrap_drained got=%0d exp=0", count); end
    endtask

    task automatic test_concurrent();
        do_reset();
        cycle(2'b11, 64'd1, 64'd2, 1'b0);
        cycle(2'b11, 64'd3, 64'd4, 1'b0);
        cycle(2'b01, 64'd5, 64'd0, 1'b0);
        checks++; if (count !== 5'd5) begin errors++; $display("FAIL conc_pre got=%0d exp=5", count); end
        for (int i = 0; i < 3; i++) cycle(2'b11, 64'($urandom), 64'($urandom), 1'b1);
        checks++; if (count !== 5'd8) begin errors++; $display("FAIL conc_count got=%0d exp=8", count); end
        checks++; if (out_data !== 64'd4) begin errors++; $display("FAIL conc_head got=%0d exp=4", out_data); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (out_data !== mq[0]) begin errors++; $display("FAIL conc_drain i=%0d got=%0h exp=%0h", i, out_data, mq[0]); end
            cycle(2'b00, '0, '0, 1'b1);
        end
        cycle(2'b00, '0, '0, 1'b1);
        checks++; if (count !== 5'd0 || out_valid !== 1'b0 || overflow_err !== 1'b0) begin
            errors++; $display("FAIL empty_deq count=%0d valid=%b ovf=%b exp=0/0/0", count, out_valid, overflow_err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 11; i++) cycle(2'b11, 64'(i), 64'(i + 50), 1'b0);
        for (int i = 0; i < 10; i++) cycle(2'b00, '0, '0, 1'b1);
        checks++; if (count !== 5'd10 || overflow_err !== 1'b1) begin
            errors++; $display("FAIL mid_pre count=%0d ovf=%b exp=10/1", count, overflow_err);
        end
        rst = 1'b0;
        cycle(2'b11, 64'd77, 64'd78, 1'b1);
        rst = 1'b1;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL mid_overflow got=%b exp=0", overflow_err); end
        cycle(2'b01, 64'd33, 64'd0, 1'b0);
        checks++; if (count !== 5'd1 || out_data !== 64'd33) begin
            errors++; $display("FAIL mid_restart count=%0d data=%0d exp=1/33", count, out_data);
        end
    endtask

    task automatic test_random();
        int pct;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            pct = ((c / 60) % 2 == 0) ? 25 : 85;
            if ($urandom_range(0, 149) == 0) rst = 1'b0;
            cycle(2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
                  $urandom_range(0, 99) < pct);
            rst = 1'b1;
            checks++; if (count !== 5'(mq.size())) begin errors++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, count, mq.size()); end
            checks++; if (out_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_out_valid c=%0d got=%b", c, out_valid); end
            checks++; if (in_valid !== ((QS - mq.size()) >= NI)) begin errors++; $display("FAIL rnd_in_valid c=%0d got=%b", c, in_valid); end
            checks++; if (almost_full !== (mq.size() >= AF)) begin errors++; $display("FAIL rnd_almost_full c=%0d got=%b", c, almost_full); end
            checks++; if (overflow_err !== m_ovf) begin errors++; $display("FAIL rnd_overflow c=%0d got=%b exp=%b", c, overflow_err, m_ovf); end
            if (mq.size() != 0) begin
                checks++; if (out_data !== mq[0]) begin errors++; $display("FAIL rnd_data c=%0d got=%0h exp=%0h", c, out_data, mq[0]); end
            end
        end
    endtask

    initial begin
        rst  = 1'b0;
        en   = '0;
        data = '0;
        deq  = 1'b0;
        @(negedge clk);
        test_reset();
        test_dual_fill();
        test_lane_packing();
        test_wrap();
        test_concurrent();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
